// File: rtl/prime_trial_div_pkg.sv
// Shared definitions for the trial-division primality engine.
// The controller state encoding and the "unlimited accuracy" constant are
// kept here so that other check engines can use the same encodings.
package prime_trial_div_pkg;

  // 3-bit controller states, in the order a test moves through them.
  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    CLASSIFY = 3'd1,
    SQTEST   = 3'd2,
    DIV      = 3'd3,
    EVAL     = 3'd4,
    DONE     = 3'd5
  } state_t;

  // An accuracy value of zero means "try every odd divisor" (exact result).
  localparam int unsigned ACC_UNLIMITED = 0;

endpackage : prime_trial_div_pkg

// File: rtl/prime_trial_div_mod_div.sv
// prime_mod_div: restoring shift-subtract remainder unit.
// A start pulse loads the operands. WORDSIZE steps follow, one per clock.
// After the last step, rem holds dividend mod divisor.
// done is high for exactly one cycle: the cycle in which the final step is
// computed. The caller may therefore leave its wait state on done and read
// rem on the next cycle.
//
// Ports:
//   clk      in   1         system clock, rising edge
//   reset    in   1         async active-high, aborts any operation
//   start    in   1         load operands and begin a new division
//   dividend in   WORDSIZE  numerator
//   divisor  in   WORDSIZE  denominator (non-zero)
//   rem      out  WORDSIZE  remainder, valid once the step count reaches zero
//   done     out  1         one-cycle pulse during the final step
module prime_mod_div #(
  parameter int WORDSIZE = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WORDSIZE-1:0] dividend,
  input  logic [WORDSIZE-1:0] divisor,
  output logic [WORDSIZE-1:0] rem,
  output logic                done
);

  localparam int CW = $clog2(WORDSIZE + 1);

  logic [WORDSIZE-1:0] dvd_q, dvd_d;   // dividend, shifted left one bit per step
  logic [WORDSIZE-1:0] dsr_q, dsr_d;
  logic [WORDSIZE-1:0] rem_q, rem_d;
  logic [CW-1:0]       cnt_q, cnt_d;   // steps remaining
  logic [WORDSIZE:0]   trial;

  // Bring down the next dividend bit. Any value that survives the subtract
  // is below the divisor, so the partial remainder always fits WORDSIZE bits.
  assign trial = {rem_q, dvd_q[WORDSIZE-1]};

  always_comb begin
    // NOTE: each variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    dvd_d = dvd_q;
    dsr_d = dsr_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (start) begin
      dvd_d = dividend;
      dsr_d = divisor;
      rem_d = '0;
      cnt_d = CW'(WORDSIZE);
    end else if (cnt_q != '0) begin
      if (trial >= {1'b0, dsr_q}) begin
        rem_d = WORDSIZE'(trial - {1'b0, dsr_q});
      end else begin
        rem_d = trial[WORDSIZE-1:0];
      end
      dvd_d = dvd_q << 1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      dvd_q <= '0;
      dsr_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign rem  = rem_q;
  assign done = (cnt_q == CW'(1));

endmodule : prime_mod_div

// File: rtl/prime_trial_div.sv
// prime_trial_div: deterministic primality responder using trial division.
// A reset pulse starts a new test. The candidate is latched on the first
// edge after reset is released. The odd divisors 3, 5, 7, ... are then
// tried until one of these happens:
//   - d*d exceeds n (prime),
//   - a divisor leaves a zero remainder (composite; factor reports it),
//   - accuracy divisors have been tried (reported as a probable prime).
//
// Ports:
//   clk          in   1           system clock, rising edge
//   reset        in   1           async active-high; also starts a new test
//   start_number in   WORDSIZE    candidate n
//   accuracy     in   2*WORDSIZE  max odd divisors to try, 0 = unlimited
//   prime        out  1           result, valid while finish=1
//   finish       out  1           test complete, held until the next reset
//   factor       out  WORDSIZE    smallest divisor found, 0 if none
module prime_trial_div
  import prime_trial_div_pkg::*;
#(
  parameter int WORDSIZE = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORDSIZE-1:0]   start_number,
  input  logic [2*WORDSIZE-1:0] accuracy,
  output logic                  prime,
  output logic                  finish,
  output logic [WORDSIZE-1:0]   factor
);

  localparam int W2 = 2 * WORDSIZE;

  state_t              state_q, state_d;
  logic [WORDSIZE-1:0] n_q, n_d;
  logic [WORDSIZE-1:0] d_q, d_d;            // current odd divisor
  logic [W2-1:0]       sq_q, sq_d;          // d*d, maintained incrementally
  logic [W2-1:0]       count_q, count_d;    // divisors fully tried
  logic                prime_q, prime_d;
  logic                finish_q, finish_d;
  logic [WORDSIZE-1:0] factor_q, factor_d;

  logic                div_start;
  logic [WORDSIZE-1:0] div_rem;
  logic                div_done;
  logic [W2-1:0]       count_inc;

  prime_mod_div #(.WORDSIZE(WORDSIZE)) u_mod_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (n_q),
    .divisor  (d_q),
    .rem      (div_rem),
    .done     (div_done)
  );

  assign count_inc = count_q + W2'(1);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    d_d       = d_q;
    sq_d      = sq_q;
    count_d   = count_q;
    prime_d   = prime_q;
    finish_d  = finish_q;
    factor_d  = factor_q;
    div_start = 1'b0;

    case (state_q)
      LOAD: begin
        n_d     = start_number;
        state_d = CLASSIFY;
      end

      CLASSIFY: begin
        if (n_q < WORDSIZE'(2)) begin
          finish_d = 1'b1;
          state_d  = DONE;
        end else if (n_q == WORDSIZE'(2) || n_q == WORDSIZE'(3)) begin
          finish_d = 1'b1;
          prime_d  = 1'b1;
          state_d  = DONE;
        end else if (!n_q[0]) begin
          finish_d = 1'b1;
          factor_d = WORDSIZE'(2);
          state_d  = DONE;
        end else begin
          d_d     = WORDSIZE'(3);
          sq_d    = W2'(9);
          count_d = '0;
          state_d = SQTEST;
        end
      end

      SQTEST: begin
        // A factor larger than sqrt(n) implies a smaller one already tried.
        if (sq_q > W2'(n_q)) begin
          finish_d = 1'b1;
          prime_d  = 1'b1;
          state_d  = DONE;
        end else begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end

      DIV: begin
        // done marks the final step, so rem is settled in EVAL.
        if (div_done) state_d = EVAL;
      end

      EVAL: begin
        if (div_rem == '0) begin
          finish_d = 1'b1;
          factor_d = d_q;
          state_d  = DONE;
        end else begin
          count_d = count_inc;
          if (accuracy != W2'(ACC_UNLIMITED) && count_inc == accuracy) begin
            finish_d = 1'b1;
            prime_d  = 1'b1;
            state_d  = DONE;
          end else begin
            // (d+2)^2 = d^2 + 4d + 4, using the divisor just tried.
            d_d     = d_q + WORDSIZE'(2);
            sq_d    = sq_q + (W2'(d_q) << 2) + W2'(4);
            state_d = SQTEST;
          end
        end
      end

      DONE: state_d = DONE;

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      n_q      <= '0;
      d_q      <= '0;
      sq_q     <= '0;
      count_q  <= '0;
      prime_q  <= 1'b0;
      finish_q <= 1'b0;
      factor_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      d_q      <= d_d;
      sq_q     <= sq_d;
      count_q  <= count_d;
      prime_q  <= prime_d;
      finish_q <= finish_d;
      factor_q <= factor_d;
    end
  end

  assign prime  = prime_q;
  assign finish = finish_q;
  assign factor = factor_q;

endmodule : prime_trial_div

// File: tb/tb_prime_trial_div.sv
// Directed bench for prime_trial_div with WORDSIZE=31. Edges are counted
// from reset release, and outputs are sampled 1 time unit after each
// rising edge.
module tb_prime_trial_div;

  localparam int W  = 31;
  localparam int W2 = 2 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  start_number = '0;
  logic [W2-1:0] accuracy = '0;
  logic          prime;
  logic          finish;
  logic [W-1:0]  factor;

  int n_checks = 0;
  int n_fail   = 0;

  prime_trial_div #(.WORDSIZE(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_number (start_number),
    .accuracy     (accuracy),
    .prime        (prime),
    .finish       (finish),
    .factor       (factor)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  n;
    logic [W2-1:0] acc;
    int            edge_no;
    logic          prime;
    logic [W-1:0]  factor;
  } vec_t;

  // Assert reset on a falling edge, present the inputs, release one cycle later.
  task automatic start_test(input logic [W-1:0] n, input logic [W2-1:0] acc);
    @(negedge clk);
    reset        = 1'b1;
    start_number = n;
    accuracy     = acc;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns the edge number at which finish first rises, or 0 on timeout.
  task automatic wait_finish(input int bound, output int got);
    got = 0;
    for (int e = 1; e <= bound; e++) begin
      @(posedge clk);
      #1;
      if (finish === 1'b1) begin
        got = e;
        break;
      end
    end
  endtask

  task automatic check_result(input string name, input int exp_edge,
                              input logic exp_prime, input logic [W-1:0] exp_factor);
    int got;
    wait_finish(exp_edge + 10, got);
    n_checks++;
    if (got !== exp_edge) begin
      n_fail++;
      $display("FAIL %s finish edge: got %0d expected %0d", name, got, exp_edge);
    end
    n_checks++;
    if (prime !== exp_prime) begin
      n_fail++;
      $display("FAIL %s prime: got %b expected %b", name, prime, exp_prime);
    end
    n_checks++;
    if (factor !== exp_factor) begin
      n_fail++;
      $display("FAIL %s factor: got %0d expected %0d", name, factor, exp_factor);
    end
  endtask

  task automatic test_reset();
    // Outputs must be clear while reset is held.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({prime, finish, factor} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got prime=%b finish=%b factor=%0d expected all 0",
               prime, finish, factor);
    end
    // Reach DONE with n=3, then assert reset between edges: clear without a clock.
    start_test(W'(3), '0);
    check_result("n3_pre_async", 2, 1'b1, '0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (finish !== 1'b0 || prime !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: got finish=%b prime=%b expected 0 0", finish, prime);
    end
  endtask

  task automatic test_vectors();
    vec_t v[17];
    v[0]  = '{W'(0),          '0,      2,   1'b0, W'(0)};
    v[1]  = '{W'(1),          '0,      2,   1'b0, W'(0)};
    v[2]  = '{W'(2),          '0,      2,   1'b1, W'(0)};
    v[3]  = '{W'(3),          '0,      2,   1'b1, W'(0)};
    v[4]  = '{W'(4),          '0,      2,   1'b0, W'(2)};
    v[5]  = '{W'(7),          '0,      3,   1'b1, W'(0)};
    v[6]  = '{W'(9),          '0,      35,  1'b0, W'(3)};
    v[7]  = '{W'(13),         '0,      36,  1'b1, W'(0)};
    v[8]  = '{W'(25),         '0,      68,  1'b0, W'(5)};
    v[9]  = '{W'(49),         '0,      101, 1'b0, W'(7)};
    v[10] = '{W'(97),         '0,      135, 1'b1, W'(0)};
    v[11] = '{W'(221),        W2'(2),  68,  1'b1, W'(0)};
    v[12] = '{W'(221),        '0,      200, 1'b0, W'(13)};
    v[13] = '{W'(9),          W2'(1),  35,  1'b0, W'(3)};
    v[14] = '{W'(25),         W2'(1),  35,  1'b1, W'(0)};
    v[15] = '{W'(2147483646), '0,      2,   1'b0, W'(2)};
    v[16] = '{W'(2147483647), W2'(1),  35,  1'b1, W'(0)};
    for (int i = 0; i < 17; i++) begin
      start_test(v[i].n, v[i].acc);
      check_result($sformatf("vec%0d_n%0d", i, v[i].n), v[i].edge_no, v[i].prime, v[i].factor);
    end
  endtask

  // Once DONE, the result holds while start_number and accuracy change.
  task automatic test_done_hold();
    start_test(W'(9), '0);
    check_result("hold_n9", 35, 1'b0, W'(3));
    start_number = W'(7);
    accuracy     = W2'(1);
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (finish !== 1'b1 || prime !== 1'b0 || factor !== W'(3)) begin
      n_fail++;
      $display("FAIL done_hold: got finish=%b prime=%b factor=%0d expected 1 0 3",
               finish, prime, factor);
    end
  endtask

  // Reset during DIV aborts the test and restarts with the new candidate.
  task automatic test_reset_mid_div();
    start_test(W'(25), '0);
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (finish !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_div_busy: got finish=%b expected 0", finish);
    end
    @(negedge clk);
    reset        = 1'b1;
    start_number = W'(4);
    #1;
    n_checks++;
    if (finish !== 1'b0 || prime !== 1'b0 || factor !== '0) begin
      n_fail++;
      $display("FAIL mid_div_clear: got finish=%b prime=%b factor=%0d expected 0 0 0",
               finish, prime, factor);
    end
    @(negedge clk);
    reset = 1'b0;
    check_result("restart_n4", 2, 1'b0, W'(2));
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_done_hold();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_prime_trial_div
